// File: rtl/png_unfilter_pkg.sv
// Shared widths, filter type codes and FSM states for the PNG unfilter stage.
package png_unfilter_pkg;

   localparam int unsigned PNG_DATA_PXL_WD = 32;
   localparam int unsigned PNG_SIZE_W_WD   = 10;
   localparam int unsigned PNG_SIZE_H_WD   = 10;
   localparam int unsigned PNG_W_MAX       = 512;
   localparam int unsigned LANE_WD         = 8;

   typedef enum logic [2:0] {
      FLT_NONE  = 3'd0,
      FLT_SUB   = 3'd1,
      FLT_UP    = 3'd2,
      FLT_AVG   = 3'd3,
      FLT_PAETH = 3'd4
   } flt_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TYPE,
      ST_PXL,
      ST_DONE
   } state_e;

endpackage

// File: rtl/png_unfilter_line_buf.sv
// Previous-row pixel store: asynchronous read, synchronous write, so a read
// at the address being written returns the old (previous-row) value.
module png_unfilter_line_buf #(
   parameter int unsigned DEPTH   = 512,
   parameter int unsigned DATA_WD = 32,
   parameter int unsigned ADDR_WD = 9
) (
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [ADDR_WD-1:0] i_waddr,
   input  logic [DATA_WD-1:0] i_wdat,
   input  logic [ADDR_WD-1:0] i_raddr,
   output logic [DATA_WD-1:0] o_rdat
);

   logic [DATA_WD-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdat;
      end
   end

   assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/png_unfilter.sv
// PNG scanline unfilter: rebuilds raw RGBA pixels from a stream of one
// filter-type beat plus W filtered pixels per row, one pixel per cycle.
module png_unfilter
   import png_unfilter_pkg::*;
#(
   parameter int unsigned DATA_PXL_WD = PNG_DATA_PXL_WD,
   parameter int unsigned SIZE_W_WD   = PNG_SIZE_W_WD,
   parameter int unsigned SIZE_H_WD   = PNG_SIZE_H_WD,
   parameter int unsigned W_MAX       = PNG_W_MAX
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [SIZE_W_WD-1:0]   cfg_w_i,
   input  logic [SIZE_H_WD-1:0]   cfg_h_i,
   input  logic                   start_i,
   output logic                   done_o,
   output logic                   err_o,
   input  logic                   val_i,
   input  logic [DATA_PXL_WD-1:0] dat_i,
   output logic                   val_o,
   output logic [DATA_PXL_WD-1:0] dat_o
);

   localparam int unsigned X_WD  = $clog2(W_MAX);
   localparam int unsigned LANES = DATA_PXL_WD / LANE_WD;

   state_e                 r_state, w_state_nxt;
   logic [SIZE_W_WD-1:0]   r_w;
   logic [SIZE_H_WD-1:0]   r_h, r_y;
   logic [X_WD-1:0]        r_x;
   flt_e                   r_ftype;
   logic                   r_err, r_val_o, r_done;
   logic [DATA_PXL_WD-1:0] r_a, r_c, r_dat_o;

   logic                   w_type_beat, w_pix_beat, w_done;
   logic                   w_x_last, w_y_last;
   logic [DATA_PXL_WD-1:0] w_b_raw, w_a, w_b, w_c, w_recon;

   function automatic logic [7:0] paeth(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
      logic signed [9:0] p, da, db, dc, pa, pb, pc;
      p  = $signed({2'b00, a}) + $signed({2'b00, b}) - $signed({2'b00, c});
      da = p - $signed({2'b00, a});
      db = p - $signed({2'b00, b});
      dc = p - $signed({2'b00, c});
      pa = (da < 0) ? -da : da;
      pb = (db < 0) ? -db : db;
      pc = (dc < 0) ? -dc : dc;
      if (pa <= pb && pa <= pc) return a;
      else if (pb <= pc)        return b;
      else                      return c;
   endfunction

   function automatic logic [7:0] recon_lane(input flt_e ft, input logic [7:0] f,
                                             input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      case (ft)
         FLT_SUB:   return f + a;
         FLT_UP:    return f + b;
         FLT_AVG:   return f + sum[8:1];
         FLT_PAETH: return f + paeth(a, b, c);
         default:   return f;
      endcase
   endfunction

   png_unfilter_line_buf #(
      .DEPTH   (W_MAX),
      .DATA_WD (DATA_PXL_WD),
      .ADDR_WD (X_WD)
   ) u_line_buf (
      .i_clk   (clk),
      .i_we    (w_pix_beat),
      .i_waddr (r_x),
      .i_wdat  (w_recon),
      .i_raddr (r_x),
      .o_rdat  (w_b_raw)
   );

   assign w_x_last = (SIZE_W_WD'(r_x) == r_w - SIZE_W_WD'(1));
   assign w_y_last = (r_y == r_h - SIZE_H_WD'(1));

   // Row/column edges force the missing neighbours to zero.
   assign w_a = (r_x == '0) ? '0 : r_a;
   assign w_b = (r_y == '0) ? '0 : w_b_raw;
   assign w_c = (r_x == '0 || r_y == '0) ? '0 : r_c;

   always_comb begin
      w_recon = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         w_recon[k*LANE_WD +: LANE_WD] = recon_lane(r_ftype, dat_i[k*LANE_WD +: LANE_WD],
                                                    w_a[k*LANE_WD +: LANE_WD],
                                                    w_b[k*LANE_WD +: LANE_WD],
                                                    w_c[k*LANE_WD +: LANE_WD]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_type_beat = 1'b0;
      w_pix_beat  = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: ;
         ST_TYPE: begin
            if (val_i) begin
               w_type_beat = 1'b1;
               w_state_nxt = ST_PXL;
            end
         end
         ST_PXL: begin
            if (val_i) begin
               w_pix_beat = 1'b1;
               if (w_x_last) w_state_nxt = w_y_last ? ST_DONE : ST_TYPE;
            end
         end
         ST_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      // A restart overrides whatever the current state would have done.
      if (start_i) begin
         w_state_nxt = ST_TYPE;
         w_type_beat = 1'b0;
         w_pix_beat  = 1'b0;
         w_done      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w     <= '0;
         r_h     <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_ftype <= FLT_NONE;
         r_err   <= 1'b0;
         r_a     <= '0;
         r_c     <= '0;
         r_val_o <= 1'b0;
         r_dat_o <= '0;
         r_done  <= 1'b0;
      end else begin
         r_val_o <= w_pix_beat;
         r_done  <= w_done;
         if (w_pix_beat) r_dat_o <= w_recon;
         if (start_i) begin
            r_w   <= cfg_w_i;
            r_h   <= cfg_h_i;
            r_x   <= '0;
            r_y   <= '0;
            r_err <= 1'b0;
         end else begin
            if (w_type_beat) begin
               r_x <= '0;
               if (dat_i[2:0] > 3'd4) begin
                  r_err   <= 1'b1;
                  r_ftype <= FLT_NONE;
               end else begin
                  r_ftype <= flt_e'(dat_i[2:0]);
               end
            end
            if (w_pix_beat) begin
               r_a <= w_recon;
               r_c <= w_b;
               if (w_x_last) begin
                  r_x <= '0;
                  if (!w_y_last) r_y <= r_y + SIZE_H_WD'(1);
               end else begin
                  r_x <= r_x + X_WD'(1);
               end
            end
         end
      end
   end

   assign val_o  = r_val_o;
   assign dat_o  = r_dat_o;
   assign done_o = r_done;
   assign err_o  = r_err;

endmodule

// File: tb/tb_png_unfilter.sv
// Directed, table-driven bench for png_unfilter with hand-computed frames.
module tb_png_unfilter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  cfg_w_i = '0;
   logic [9:0]  cfg_h_i = '0;
   logic        start_i = 1'b0;
   logic        val_i = 1'b0;
   logic [31:0] dat_i = '0;
   logic        done_o, err_o, val_o;
   logic [31:0] dat_o;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int          out_cyc[$];
   logic [31:0] out_dat[$];
   int          done_cyc[$];

   typedef struct {
      string       name;
      int          w;
      int          h;
      logic [2:0]  ft [2];
      logic [31:0] din [8];
      logic [31:0] dout [8];
      bit          gap;
      bit          exp_err;
   } vec_t;

   vec_t tbl [8];

   png_unfilter #(
      .DATA_PXL_WD (32),
      .SIZE_W_WD   (10),
      .SIZE_H_WD   (10),
      .W_MAX       (512)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .cfg_w_i (cfg_w_i),
      .cfg_h_i (cfg_h_i),
      .start_i (start_i),
      .done_o  (done_o),
      .err_o   (err_o),
      .val_i   (val_i),
      .dat_i   (dat_i),
      .val_o   (val_o),
      .dat_o   (dat_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (val_o) begin
         out_cyc.push_back(cyc);
         out_dat.push_back(dat_o);
      end
      if (done_o) done_cyc.push_back(cyc);
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon;
      out_cyc.delete();
      out_dat.delete();
      done_cyc.delete();
   endtask

   task automatic set_vec(input int i, input string name, input int w, input int h,
                          input logic [2:0] ft0, input logic [2:0] ft1,
                          input bit gap, input bit exp_err);
      tbl[i].name    = name;
      tbl[i].w       = w;
      tbl[i].h       = h;
      tbl[i].ft[0]   = ft0;
      tbl[i].ft[1]   = ft1;
      tbl[i].gap     = gap;
      tbl[i].exp_err = exp_err;
   endtask

   task automatic run_vec(input int i);
      int n;
      int waited;
      clear_mon();
      cfg_w_i = 10'(tbl[i].w);
      cfg_h_i = 10'(tbl[i].h);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check32({tbl[i].name, "/err_clr"}, {31'b0, err_o}, 32'd0);
      n = 0;
      for (int r = 0; r < tbl[i].h; r++) begin
         val_i = 1'b1;
         dat_i = 32'hA5A5A5A0 | {29'b0, tbl[i].ft[r]};
         tick();
         for (int x = 0; x < tbl[i].w; x++) begin
            val_i = 1'b1;
            dat_i = tbl[i].din[n];
            n++;
            tick();
            if (tbl[i].gap) begin
               val_i = 1'b0;
               dat_i = 32'hDEADBEEF;
               tick();
            end
         end
      end
      val_i = 1'b0;
      waited = 0;
      while (done_cyc.size() == 0 && waited < 20) begin
         tick();
         waited++;
      end
      tick();
      check32({tbl[i].name, "/done_cnt"}, done_cyc.size(), 32'd1);
      check32({tbl[i].name, "/nout"}, out_dat.size(), n);
      for (int k = 0; k < n && k < out_dat.size(); k++)
         check32($sformatf("%s/pix%0d", tbl[i].name, k), out_dat[k], tbl[i].dout[k]);
      if (done_cyc.size() > 0 && out_cyc.size() > 0)
         check32({tbl[i].name, "/done_lat"}, done_cyc[0] - out_cyc[out_cyc.size()-1], 32'd1);
      if (!tbl[i].gap && out_cyc.size() > 0)
         check32({tbl[i].name, "/span"}, out_cyc[out_cyc.size()-1] - out_cyc[0],
                 n + tbl[i].h - 2);
      check32({tbl[i].name, "/err"}, {31'b0, err_o}, {31'b0, tbl[i].exp_err});
   endtask

   initial begin
      set_vec(0, "none4x2", 4, 2, 3'd0, 3'd0, 1'b0, 1'b0);
      tbl[0].din  = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10,
                      32'h11121314, 32'h15161718, 32'h191A1B1C, 32'h1D1E1F20};
      tbl[0].dout = tbl[0].din;
      set_vec(1, "sub_w3", 3, 1, 3'd1, 3'd0, 1'b1, 1'b0);
      tbl[1].din  = '{32'h01010101, 32'h01010101, 32'h01010101, 0, 0, 0, 0, 0};
      tbl[1].dout = '{32'h01010101, 32'h02020202, 32'h03030303, 0, 0, 0, 0, 0};
      set_vec(2, "sub_wrap", 2, 1, 3'd1, 3'd0, 1'b0, 1'b0);
      tbl[2].din  = '{32'hFFFFFFFF, 32'h02020202, 0, 0, 0, 0, 0, 0};
      tbl[2].dout = '{32'hFFFFFFFF, 32'h01010101, 0, 0, 0, 0, 0, 0};
      set_vec(3, "up", 2, 2, 3'd2, 3'd2, 1'b0, 1'b0);
      tbl[3].din  = '{32'h10203040, 32'h50607080, 32'h01010101, 32'hFFFFFFFF, 0, 0, 0, 0};
      tbl[3].dout = '{32'h10203040, 32'h50607080, 32'h11213141, 32'h4F5F6F7F, 0, 0, 0, 0};
      set_vec(4, "avg", 2, 2, 3'd0, 3'd3, 1'b0, 1'b0);
      tbl[4].din  = '{32'h0F0F0F0F, 32'h14141414, 32'h03030303, 32'h01010101, 0, 0, 0, 0};
      tbl[4].dout = '{32'h0F0F0F0F, 32'h14141414, 32'h0A0A0A0A, 32'h10101010, 0, 0, 0, 0};
      set_vec(5, "paeth", 2, 2, 3'd0, 3'd4, 1'b0, 1'b0);
      tbl[5].din  = '{32'h0F0F0F0F, 32'h14141414, 32'hFBFBFBFB, 32'h01010101, 0, 0, 0, 0};
      tbl[5].dout = '{32'h0F0F0F0F, 32'h14141414, 32'h0A0A0A0A, 32'h10101010, 0, 0, 0, 0};
      set_vec(6, "bad_type", 2, 1, 3'd7, 3'd0, 1'b0, 1'b1);
      tbl[6].din  = '{32'h11223344, 32'h01010101, 0, 0, 0, 0, 0, 0};
      tbl[6].dout = tbl[6].din;
      set_vec(7, "w1h1", 1, 1, 3'd1, 3'd0, 1'b0, 1'b0);
      tbl[7].din  = '{32'h05060708, 0, 0, 0, 0, 0, 0, 0};
      tbl[7].dout = tbl[7].din;

      #12;
      check32("rst_val_o", {31'b0, val_o}, 32'd0);
      check32("rst_dat_o", dat_o, 32'd0);
      check32("rst_done_o", {31'b0, done_o}, 32'd0);
      check32("rst_err_o", {31'b0, err_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      clear_mon();
      for (int k = 0; k < 3; k++) begin
         val_i = 1'b1;
         dat_i = 32'h12345678 + k;
         tick();
      end
      val_i = 1'b0;
      tick();
      tick();
      check32("idle_ignored", out_dat.size(), 32'd0);

      for (int i = 0; i < 8; i++) run_vec(i);

      clear_mon();
      cfg_w_i = 10'd4;
      cfg_h_i = 10'd2;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      val_i = 1'b1;
      dat_i = 32'h0;
      tick();
      dat_i = 32'h11111111;
      tick();
      dat_i = 32'h22222222;
      tick();
      val_i = 1'b0;
      check32("pre_rst_val_o", {31'b0, val_o}, 32'd1);
      check32("pre_rst_dat_o", dat_o, 32'h22222222);
      #2 rst = 1'b1;
      #1;
      check32("mid_rst_val_o", {31'b0, val_o}, 32'd0);
      check32("mid_rst_dat_o", dat_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      clear_mon();
      repeat (5) tick();
      check32("rst_no_done", done_cyc.size(), 32'd0);
      tbl[3].name = "up_after_rst";
      run_vec(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/png_unfilter.md
Name: png_unfilter

Overview:
- Inverse of the encoder's filter stage, and the first stage of the decode path after inflate.
- Accepts a scanline stream of one filter-type beat followed by W filtered RGBA pixels, and rebuilds the raw RGBA pixels.
- Applies the PNG filters None, Sub, Up, Average and Paeth per byte lane.
- Keeps the previous reconstructed row in a line buffer. Output feeds the pixel checker or a frame store.

Parameters:
- DATA_PXL_WD, 32, pixel width (4 byte lanes: R,G,B,A; lane k = dat[8k+7:8k]).
- SIZE_W_WD, 10, width of cfg_w_i.
- SIZE_H_WD, 10, width of cfg_h_i.
- W_MAX, 512, line-buffer depth in pixels; cfg_w_i must be ≤ W_MAX.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_w_i  in  SIZE_W_WD  image width in pixels, sampled at start_i.
- cfg_h_i  in  SIZE_H_WD  image height in rows, sampled at start_i.
- start_i  in  1  one-cycle pulse that begins a frame.
- done_o  out  1  one-cycle pulse after the last pixel of the frame is output.
- err_o  out  1  sticky: an illegal filter type was seen; cleared by start_i.
- val_i  in  1  input beat valid; no backpressure.
- dat_i  in  DATA_PXL_WD  filter-type beat (type in dat_i[2:0]) or filtered pixel.
- val_o  out  1  reconstructed pixel valid.
- dat_o  out  DATA_PXL_WD  reconstructed RGBA pixel.

Behaviour:
- Reset values: val_o=0, dat_o=0, done_o=0, err_o=0, state=IDLE, all counters 0. Line-buffer contents are don't-care.
- Reset is asynchronous and active-high. Asserting it mid-frame aborts the frame immediately; no done_o is issued.
- FSM:
  - IDLE: on start_i, latch cfg_w_i/cfg_h_i, clear x, y and err_o, go to TYPE.
  - TYPE: on val_i, latch ftype=dat_i[2:0]. If ftype>4, set err_o and use ftype=0. Set x=0, go to PXL.
  - PXL: each val_i beat processes one pixel at x, then x++. On the beat with x=W-1:
    - if y=H-1, go to DONE;
    - otherwise y++ and go to TYPE.
  - DONE: wait for the last val_o to have been issued, pulse done_o, go to IDLE.
- start_i in any non-IDLE state restarts the frame: x, y and err_o are cleared, the new cfg is latched, state goes to TYPE, and any output still in flight is still emitted.
- val_i in IDLE or DONE is ignored.
- Per-lane operands (8-bit, modulo 256):
  - a = left pixel, i.e. the previous output of this row; a=0 when x=0.
  - b = pixel above, read from the line buffer at x; b=0 when y=0.
  - c = above-left, the registered b from x-1; c=0 when x=0 or y=0.
- Per-lane reconstruction, with f = filtered byte:
  - 0 None: f
  - 1 Sub: f+a
  - 2 Up: f+b
  - 3 Avg: f+floor((a+b)/2), with the sum computed at 9 bits.
  - 4 Paeth: f+pr, where p=a+b−c is signed 10-bit; pa=|p−a|, pb=|p−b|, pc=|p−c|.
    - pr=a if pa≤pb and pa≤pc;
    - else pr=b if pb≤pc;
    - else pr=c.
- Latency: 1 cycle. A pixel beat at edge n gives val_o/dat_o valid at edge n+1.
- Sustained rate: 1 pixel per cycle. val_i may be high on every cycle, including the type beat directly after the last pixel of the previous row.
- The result is written back to the line buffer at x in the same cycle it is produced. The read of b at x must return the previous row's value (read-before-write).
- Widths: x counts to W_MAX−1 and y counts to 2^SIZE_H_WD−1. W=1 and H=1 are legal.
- Filter-type beats never produce val_o.

Decomposition:
- Shared defines header holds DATA_PXL_WD, SIZE_W_WD, SIZE_H_WD and the filter type codes FLT_NONE=0, FLT_SUB=1, FLT_UP=2, FLT_AVG=3, FLT_PAETH=4.
- Sub-module png_unfilter_line_buf: W_MAX×DATA_PXL_WD memory, 1 read/1 write port, asynchronous read, synchronous write, read-before-write at the same address.
- The Paeth predictor is a function inside png_unfilter, instantiated 4× (one per lane).

Test Plan:
- 4×2 frame, all None, pixels 0x01020304…: output equals input, 8 val_o beats, done_o exactly 1 cycle after the 8th val_o.
- Sub row, W=3, inputs 0x01010101 ×3: outputs 0x01010101, 0x02020202, 0x03030303. Lane wrap: 0xFF+0x02 → 0x01.
- Row0 None 0x10203040, row1 Up with f=0x01010101: out 0x11213141. Up on row 0 behaves as None.
- Avg and Paeth, lane values a=10, b=20, c=15: Avg pred=15; Paeth p=15, pa=5, pb=5, pc=0 → pr=c=15. Both cases checked against the golden model on 256×256 RGBA.dat, with the result matching the original RGBA.
- Filter type 7 beat: err_o=1 and the row is decoded as None. A following start_i clears err_o.
- Back-to-back val_i across row boundaries: 1 pixel/cycle throughput, no dropped beats. rst asserted mid-row: all outputs 0 asynchronously, and the next frame decodes correctly.
